// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART byte receiver, 16x oversampling, 3-sample majority vote per bit.
// Ports: clk (50 MHz), rst_n (async active-low), rs232_rx (serial in, idle high),
//        baud_set (0:9600 1:19200 2:38400 3:57600 4:115200 else 9600),
//        data_byte (last good byte), rx_done (1-cycle strobe), rx_state (frame in progress),
//        frame_err (1-cycle bad-stop strobe, only when UART_RX_FRAME_ERR_EN is defined).
module uart_byte_rx (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rs232_rx,
   input  logic [2:0] baud_set,
   output logic [7:0] data_byte,
   output logic       rx_done,
   output logic       rx_state,
   output logic       frame_err
);
   typedef enum logic {IDLE, RECV} state_t;
   state_t      state;
   logic        sync1, sync2, sync2_d;
   logic [15:0] div_cnt, term, term_sel;
   logic [7:0]  os_cnt, shreg;
   logic [1:0]  vote;
   logic [3:0]  slot, bit_idx;
   logic        os_tick, start_edge, bit_val;
   always_comb begin
      term_sel   = baud_set == 3'd1 ? 16'd162 :
                   baud_set == 3'd2 ? 16'd80  :
                   baud_set == 3'd3 ? 16'd53  :
                   baud_set == 3'd4 ? 16'd26  : 16'd324;
      start_edge = sync2_d & ~sync2;
      os_tick    = (state == RECV) && (div_cnt == term);
      slot       = os_cnt[3:0];
      bit_idx    = os_cnt[7:4];
      // third sample is the live one; the first two are already in vote
      bit_val    = ({1'b0, vote} + {2'b00, sync2}) >= 3'd2;
   end
`ifndef UART_RX_FRAME_ERR_EN
   assign frame_err = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         sync2_d   <= 1'b1;
         state     <= IDLE;
         div_cnt   <= '0;
         term      <= '0;
         os_cnt    <= '0;
         shreg     <= '0;
         vote      <= '0;
         data_byte <= '0;
         rx_done   <= 1'b0;
         rx_state  <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
      end else begin
         sync1   <= rs232_rx;
         sync2   <= sync1;
         sync2_d <= sync2;
         rx_done <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
         frame_err <= 1'b0;
`endif
         if (state == IDLE) begin
            if (start_edge) begin
               state    <= RECV;
               rx_state <= 1'b1;
               div_cnt  <= '0;
               os_cnt   <= '0;
               vote     <= '0;
               term     <= term_sel;
            end
         end else begin
            div_cnt <= os_tick ? 16'd0 : div_cnt + 16'd1;
            if (os_tick) begin
               os_cnt <= os_cnt + 8'd1;
               if (slot == 4'd7 || slot == 4'd8)
                  vote <= vote + {1'b0, sync2};
               if (slot == 4'd9) begin
                  vote <= '0;
                  if (bit_idx == 4'd0 && bit_val) begin
                     state    <= IDLE;
                     rx_state <= 1'b0;
                  end else if (bit_idx >= 4'd1 && bit_idx <= 4'd8) begin
                     shreg <= {bit_val, shreg[7:1]};
                  end else if (bit_idx == 4'd9) begin
                     // frame closes at mid-stop so a back-to-back start edge is caught
                     state    <= IDLE;
                     rx_state <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
                     rx_done   <= bit_val;
                     frame_err <= ~bit_val;
                     if (bit_val) data_byte <= shreg;
`else
                     rx_done   <= 1'b1;
                     data_byte <= shreg;
`endif
                  end
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: self-checking bench for uart_byte_rx.
module tb_uart_byte_rx;
   logic       clk = 1'b0;
   logic       rst_n, rs232_rx, rx_done, rx_state, frame_err;
   logic [2:0] baud_set;
   logic [7:0] data_byte;
   int vectors = 0;
   int miscompares = 0;
   int done_q[$];
   int len_q[$];
   int err_n = 0;
   int both_n = 0;
   int misalign = 0;
   int run = 0;
   logic prev_state = 1'b0;
   logic [7:0] b;
   int sp;

   always #10 clk = ~clk;

   uart_byte_rx dut (
      .clk(clk), .rst_n(rst_n), .rs232_rx(rs232_rx), .baud_set(baud_set),
      .data_byte(data_byte), .rx_done(rx_done), .rx_state(rx_state), .frame_err(frame_err)
   );

   always @(negedge clk) begin
      if (rx_done) done_q.push_back(int'(data_byte));
      if (frame_err) err_n++;
      if (rx_done && frame_err) both_n++;
      if ((rx_done || frame_err) && !(prev_state && !rx_state)) misalign++;
      if (rx_state) run++;
      else if (prev_state) begin
         len_q.push_back(run);
         run = 0;
      end
      prev_state = rx_state;
   end

   function automatic int term_of(input int bs);
      return bs == 1 ? 162 : bs == 2 ? 80 : bs == 3 ? 53 : bs == 4 ? 26 : 324;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      rs232_rx = 1'b1;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_obs();
      done_q.delete();
      len_q.delete();
      err_n = 0;
   endtask

   // one frame with bit period 16*(t+1); optional inverted window around the
   // slot-8 sample of data bit 'spike'; stop_at truncates the frame (cycles)
   task automatic drive_frame(input logic [7:0] d, input int t, input logic stop_v,
                              input int spike, input int stop_at);
      int bp;
      int n;
      logic [9:0] fr;
      bp = 16 * (t + 1);
      n  = (stop_at < 0) ? 10 * bp : stop_at;
      fr = {stop_v, d, 1'b0};
      for (int c = 0; c < n; c++) begin
         int i;
         int r;
         logic v;
         i = c / bp;
         r = c % bp;
         v = fr[i];
         if (i == spike + 1 && r >= (17 * (t + 1)) / 2 && r < (19 * (t + 1)) / 2) v = ~v;
         rs232_rx = v;
         @(posedge clk); #1;
      end
   endtask

   task automatic send_check(input string tag, input logic [7:0] d, input int bs, input int spike);
      int t;
      t = term_of(bs);
      clear_obs();
      baud_set = 3'(bs);
      drive_frame(d, t, 1'b1, spike, -1);
      idle(20);
      chk({tag, "_cnt"}, done_q.size(), 1);
      chk({tag, "_val"}, done_q.size() > 0 ? done_q[0] : -1, int'(d));
      chk({tag, "_len"}, len_q.size() > 0 ? len_q[0] : -1, 154 * (t + 1));
      chk({tag, "_byte"}, data_byte, d);
   endtask

   initial begin
      rst_n = 1'b0;
      rs232_rx = 1'b1;
      baud_set = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", data_byte, 8'h00);
      chk("rst_done", rx_done, 1'b0);
      chk("rst_state", rx_state, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      rst_n = 1'b1;
      idle(10);

      send_check("single55", 8'h55, 3, -1);

      clear_obs();
      baud_set = 3'd4;
      drive_frame(8'hA3, 26, 1'b1, -1, -1);
      drive_frame(8'h0F, 26, 1'b1, -1, -1);
      idle(20);
      chk("b2b_cnt", done_q.size(), 2);
      chk("b2b_v0", done_q.size() > 0 ? done_q[0] : -1, 8'hA3);
      chk("b2b_v1", done_q.size() > 1 ? done_q[1] : -1, 8'h0F);
      chk("b2b_len1", len_q.size() > 1 ? len_q[1] : -1, 154 * 27);

      send_check("spike_b3", 8'h5A, 4, 3);
      for (int k = 0; k < 3; k++) begin
         b  = 8'($urandom);
         sp = int'($urandom_range(0, 8)) - 1;
         send_check("rand", b, 4, sp);
      end

      clear_obs();
      baud_set = 3'd6;
      rs232_rx = 1'b0;
      repeat (5 * 325) begin @(posedge clk); #1; end
      idle(11 * 325);
      chk("glitch_done", done_q.size(), 0);
      chk("glitch_len", len_q.size() > 0 ? len_q[0] : -1, 10 * 325);

      clear_obs();
      b = data_byte;
      baud_set = 3'd4;
      drive_frame(8'hC6, 26, 1'b0, -1, -1);
      idle(20);
`ifdef UART_RX_FRAME_ERR_EN
      chk("badstop_err", err_n, 1);
      chk("badstop_done", done_q.size(), 0);
      chk("badstop_byte", data_byte, b);
`else
      chk("badstop_err", err_n, 0);
      chk("badstop_done", done_q.size(), 1);
      chk("badstop_byte", data_byte, 8'hC6);
`endif

      drive_frame(8'hE7, 26, 1'b1, -1, 5 * 432 + 216);
      rs232_rx = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("midrst_data", data_byte, 8'h00);
      chk("midrst_done", rx_done, 1'b0);
      chk("midrst_state", rx_state, 1'b0);
      chk("midrst_ferr", frame_err, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_obs();
      idle(50);
      chk("postrst_state", rx_state, 1'b0);
      chk("postrst_len", len_q.size(), 0);
      send_check("after_rst81", 8'h81, 4, -1);

      clear_obs();
      baud_set = 3'd2;
      fork
         drive_frame(8'h3C, 80, 1'b1, -1, -1);
         begin
            repeat (3000) @(posedge clk);
            #1;
            baud_set = 3'd3;
         end
      join
      idle(20);
      chk("bchg_val", done_q.size() > 0 ? done_q[0] : -1, 8'h3C);
      chk("bchg_len", len_q.size() > 0 ? len_q[0] : -1, 154 * 81);
      send_check("bchg_next", 8'h96, 3, -1);

      chk("done_and_err", both_n, 0);
      chk("strobe_align", misalign, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
